// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : MIPS pipeline MEM stage. Issues loads/stores to a
//                variable-latency data memory over a req/ack handshake and
//                produces the registered writeback bundle (m_data, m_rd,
//                m_regwrite). While an access is outstanding, stall freezes
//                the upstream IF/ID/EX stages.
//
//  Ports       : clk, rst_n (async, active-low)
//                ex_result / ex_write_data / ex_rd / ex_memread /
//                ex_memwrite / ex_memtoreg / ex_regwrite  - from EX
//                mem_req / mem_we / mem_addr / mem_wdata  - to memory
//                mem_rdata / mem_ack                      - from memory
//                stall                                    - to IF/ID/EX
//                m_data / m_rd / m_regwrite               - to WB / forwarding
//                mem_err                                  - sticky abort flag
//
//  Options     : MEM_TIMEOUT_EN - when defined, a WAIT that sees no ack for
//                TIMEOUT cycles is abandoned and mem_err is set. When not
//                defined, WAIT lasts until ack and mem_err is tied to 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_write_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_memtoreg,
    input  logic              ex_regwrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic [DATA_W-1:0] m_data,
    output logic [4:0]        m_rd,
    output logic              m_regwrite,
    output logic              mem_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Operation captured on the IDLE->WAIT edge; held for the whole WAIT.
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [4:0]        r_rd;
    logic              r_memtoreg;
    logic              r_regwrite;

    // Writeback bundle.
    logic [DATA_W-1:0] r_m_data;
    logic [4:0]        r_m_rd;
    logic              r_m_regwrite;

    logic              w_access;
    logic              w_abort;

    assign w_access = ex_memread | ex_memwrite;

`ifdef MEM_TIMEOUT_EN
    localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_mem_err;

    // An ack in the final cycle still wins over the abort.
    assign w_abort = (r_state == ST_WAIT) & ~mem_ack & (r_wait_cnt == c_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_wait_cnt <= '0;
            end else if (!mem_ack) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_abort) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_abort = 1'b0;
    // TIMEOUT only matters when the abort counter exists.
    assign mem_err = 1'b0 & (TIMEOUT > 0);
`endif

    // ------------------------------------------------------------------------
    // Next-state and stall decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall = w_access;
                if (w_access) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Stall drops in the completion cycle so EX advances on the
                // same edge that retires the memory op.
                stall = ~mem_ack & ~w_abort;
                if (mem_ack || w_abort) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, capture and writeback registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_result     <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_rd         <= 5'd0;
            r_memtoreg   <= 1'b0;
            r_regwrite   <= 1'b0;
            r_m_data     <= '0;
            r_m_rd       <= 5'd0;
            r_m_regwrite <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_result     <= ex_result;
                        r_wdata      <= ex_write_data;
                        // read+write together is treated as a write
                        r_we         <= ex_memwrite;
                        r_rd         <= ex_rd;
                        r_memtoreg   <= ex_memtoreg;
                        r_regwrite   <= ex_regwrite;
                        r_m_regwrite <= 1'b0;
                    end else begin
                        r_m_data     <= ex_result;
                        r_m_rd       <= ex_rd;
                        r_m_regwrite <= ex_regwrite & (ex_rd != 5'd0);
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        r_m_data     <= (r_memtoreg & ~r_we) ? mem_rdata : r_result;
                        r_m_rd       <= r_rd;
                        r_m_regwrite <= r_regwrite & ~r_we & (r_rd != 5'd0);
                    end else begin
                        r_m_regwrite <= 1'b0;
                    end
                end
                default: begin
                    r_m_regwrite <= 1'b0;
                end
            endcase
        end
    end

    // Request is a pure state decode so it cannot glitch.
    assign mem_req    = (r_state == ST_WAIT);
    assign mem_we     = r_we;
    assign mem_addr   = r_result[ADDR_W-1:0];
    assign mem_wdata  = r_wdata;
    assign m_data     = r_m_data;
    assign m_rd       = r_m_rd;
    assign m_regwrite = r_m_regwrite;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Scoreboard bench for mem_access_stage. The driver issues
//                directed and random instructions, computes each expected
//                writeback from a word-addressed memory model and queues it;
//                a monitor pops and compares whenever the stage retires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] ex_result;
    logic [31:0] ex_write_data;
    logic [4:0]  ex_rd;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_memtoreg;
    logic        ex_regwrite;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    logic        m_regwrite;
    logic        mem_err;

    mem_access_stage #(
        .DATA_W (32),
        .ADDR_W (32),
        .TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_result    (ex_result),
        .ex_write_data(ex_write_data),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .ex_memwrite  (ex_memwrite),
        .ex_memtoreg  (ex_memtoreg),
        .ex_regwrite  (ex_regwrite),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .stall        (stall),
        .m_data       (m_data),
        .m_rd         (m_rd),
        .m_regwrite   (m_regwrite),
        .mem_err      (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regwrite;
    } wb_t;

    wb_t         sb[$];
    logic [31:0] mem_model [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: decide at the edge whether the stage retires an instruction,
    // then compare the registered bundle just after it.
    always @(posedge clk) begin : monitor
        logic retire;
        wb_t  e;
        if (mon_en && rst_n) begin
            retire = mem_req ? mem_ack : ~stall;
            #1;
            if (retire) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: retire with m_data %h, expected no retire", m_data);
                end else begin
                    e = sb.pop_front();
                    chk("wb_data", m_data, e.data);
                    chk("wb_rd", {27'd0, m_rd}, {27'd0, e.rd});
                    chk("wb_regwrite", {31'd0, m_regwrite}, {31'd0, e.regwrite});
                end
            end else begin
                chk("bubble_regwrite", {31'd0, m_regwrite}, 32'd0);
            end
        end
    end

    task automatic drive_ex(input logic [31:0] res, input logic [31:0] wd, input logic [4:0] rd,
                            input logic rdop, input logic wrop, input logic m2r, input logic rw);
        ex_result     = res;
        ex_write_data = wd;
        ex_rd         = rd;
        ex_memread    = rdop;
        ex_memwrite   = wrop;
        ex_memtoreg   = m2r;
        ex_regwrite   = rw;
    endtask

    // Issue one instruction. lat = number of WAIT cycles without ack before
    // the ack cycle.
    task automatic issue(input logic [31:0] res, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rdop, input logic wrop, input logic m2r, input logic rw,
                         input int lat);
        wb_t         e;
        logic [31:0] rdata_v;
        @(negedge clk);
        mem_ack = 1'b0;
        drive_ex(res, wd, rd, rdop, wrop, m2r, rw);
        mon_en = 1'b1;
        if (!(rdop || wrop)) begin
            e.data     = res;
            e.rd       = rd;
            e.regwrite = rw && (rd != 5'd0);
            sb.push_back(e);
            #1 chk("stall_alu", {31'd0, stall}, 32'd0);
            return;
        end
        if (wrop) begin
            mem_model[res] = wd;
            rdata_v        = $urandom;
            e.data         = res;
            e.rd           = rd;
            e.regwrite     = 1'b0;
        end else begin
            if (!mem_model.exists(res)) mem_model[res] = $urandom;
            rdata_v    = mem_model[res];
            e.data     = m2r ? rdata_v : res;
            e.rd       = rd;
            e.regwrite = rw && (rd != 5'd0);
        end
        sb.push_back(e);
        #1;
        chk("stall_access", {31'd0, stall}, 32'd1);
        chk("req_before_capture", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < lat; k++) begin
            // Upstream is frozen; scrambling EX proves nothing is re-captured.
            ex_result     = $urandom;
            ex_write_data = $urandom;
            ex_rd         = 5'($urandom);
            #1;
            chk("wait_req", {31'd0, mem_req}, 32'd1);
            chk("wait_we", {31'd0, mem_we}, {31'd0, wrop});
            chk("wait_addr", mem_addr, res);
            chk("wait_wdata", mem_wdata, wd);
            chk("wait_stall", {31'd0, stall}, 32'd1);
            @(negedge clk);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata_v;
        #1;
        chk("ack_req", {31'd0, mem_req}, 32'd1);
        chk("ack_addr", mem_addr, res);
        chk("ack_stall", {31'd0, stall}, 32'd0);
    endtask

    task automatic quiesce();
        @(negedge clk);
        mon_en  = 1'b0;
        mem_ack = 1'b0;
        drive_ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mdata"}, m_data, 32'd0);
        chk({tag, "_mrd"}, {27'd0, m_rd}, 32'd0);
        chk({tag, "_mregwrite"}, {31'd0, m_regwrite}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_err"}, {31'd0, mem_err}, 32'd0);
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        mem_ack = 1'b0;
        drive_ex(32'h200, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        mon_en = 1'b1;
        @(negedge clk);
        #1 chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
        #1;
        mon_en = 1'b0;
        drive_ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1 check_all_zero("rst_wait");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("idle_ack_regwrite", {31'd0, m_regwrite}, 32'd0);
        chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
        chk("idle_ack_data", m_data, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic timeout_never_ack();
        int n;
        @(negedge clk);
        mem_ack = 1'b0;
        drive_ex(32'h300, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        mon_en = 1'b1;
        @(negedge clk);
        n = 1;
        while (stall && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_wait_cycles", n, 32'd16);
        chk("timeout_abort_req", {31'd0, mem_req}, 32'd1);
        mon_en = 1'b0;
        drive_ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("timeout_err_set", {31'd0, mem_err}, 32'd1);
        chk("timeout_req_drop", {31'd0, mem_req}, 32'd0);
        chk("timeout_regwrite", {31'd0, m_regwrite}, 32'd0);
    endtask
`endif

    initial begin
        int          kind;
        logic [31:0] addr;
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        drive_ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        #1 rst_n = 1'b1;

        // ALU op
        issue(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        // Load with ack in the first WAIT cycle
        mem_model[32'h40] = 32'hDEAD_BEEF;
        issue(32'h40, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        // Store with four WAIT cycles before ack
        issue(32'h80, 32'hA5A5_A5A5, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 4);
        // Writes to $0 never enable writeback
        issue(32'h5555, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        issue(32'h40, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        // Read and write together is a write; read back the stored value
        issue(32'h84, 32'h1357_9BDF, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        issue(32'h84, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        // Load without memtoreg writes back the address value
        issue(32'h88, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        quiesce();

        reset_in_wait();

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 7);
            addr = 32'h1000 + {27'd0, 3'($urandom), 2'b00};
            case (kind)
                0, 1, 2, 3: issue($urandom, $urandom, 5'($urandom), 1'b0, 1'b0,
                                  1'($urandom), 1'($urandom), 0);
                4, 5:       issue(addr, $urandom, 5'($urandom), 1'b1, 1'b0,
                                  1'($urandom), 1'($urandom), $urandom_range(0, 5));
                6:          issue(addr, $urandom, 5'($urandom), 1'b0, 1'b1,
                                  1'($urandom), 1'($urandom), $urandom_range(0, 5));
                default:    issue(addr, $urandom, 5'($urandom), 1'b1, 1'b1,
                                  1'($urandom), 1'($urandom), $urandom_range(0, 5));
            endcase
        end
        quiesce();

`ifdef MEM_TIMEOUT_EN
        // Ack in the abort cycle completes normally
        issue(32'h300, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 15);
        quiesce();
        #1 chk("timeout_ack_err", {31'd0, mem_err}, 32'd0);
        timeout_never_ack();
        issue(32'h77, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        quiesce();
        #1 chk("timeout_err_sticky", {31'd0, mem_err}, 32'd1);
        rst_n = 1'b0;
        #1 chk("timeout_err_reset", {31'd0, mem_err}, 32'd0);
        #2 rst_n = 1'b1;
`endif

        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
